// File: rtl/vga_pkg.sv
// Shared 1280x800@60 timing constants and colour packing, used by the scan-out
// stage and by the pixel-colour logic that must agree on the active area.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int H_FP_DEF     = 64;
  localparam int H_SYNC_DEF   = 136;
  localparam int H_BP_DEF     = 200;
  localparam int V_ACTIVE_DEF = 800;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BP_DEF     = 24;

  localparam int H_TOTAL  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END   = HS_START + H_SYNC_DEF;
  localparam int VS_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END   = VS_START + V_SYNC_DEF;

  localparam int PIX_LAT_MAX = 4;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Per-coordinate timing flags; hs/vs here mean "asserted", not pin level.
  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } sync_t;

endpackage

// File: rtl/vga_scan_out_sync_delay.sv
// Delay line for the {visible, hs, vs} flags so they line up with colour
// returning from the pixel logic. Depth 0 is a plain wire.
module sync_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk_83,
  input  logic       rst,
  input  logic [2:0] i_sync,
  output logic [2:0] o_sync
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused;
    assign w_unused = clk_83 ^ rst;
    assign o_sync   = i_sync;
  end else begin : g_pipe
    logic [2:0] r_pipe [DEPTH];

    // Reset loads all-zero: not visible, both syncs inactive.
    always_ff @(posedge clk_83) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) r_pipe[i] <= 3'b000;
      end else begin
        r_pipe[0] <= i_sync;
        for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign o_sync = r_pipe[DEPTH-1];
  end

endmodule

// File: rtl/vga_scan_out.sv
// Pixel timing generator and VGA output stage: scans draw_x/draw_y, realigns
// sync/blank with the returned colour and registers everything onto the pins.
module vga_scan_out
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b1,
  parameter int   PIX_LAT  = 1
) (
  input  logic        clk_83,
  input  logic        rst,
  input  logic [11:0] pix_rgb,
  output logic [10:0] draw_x,
  output logic [9:0]  draw_y,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_tick,
  output logic        active
);

  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_LO  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_HI  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_LO  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_TICK = 10'(V_ACTIVE - 1);

  logic [10:0] r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic        w_h_wrap;
  logic        w_v_wrap;
  sync_t       w_sync_raw;
  sync_t       w_sync_dly;
  rgb_t        w_pix;
  rgb_t        r_rgb;
  logic        r_hs;
  logic        r_vs;
  logic        r_active;
  logic        r_frame_tick;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);
  assign w_pix    = pix_rgb;

  always_ff @(posedge clk_83) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 11'd1;
    end
  end

  // Fires on the edge that moves the counters onto (0, V_ACTIVE); not delayed.
  always_ff @(posedge clk_83) begin
    if (rst) r_frame_tick <= 1'b0;
    else     r_frame_tick <= w_h_wrap && (r_v_cnt == V_TICK);
  end

  always_comb begin
    w_sync_raw     = '0;
    w_sync_raw.vis = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    w_sync_raw.hs  = (r_h_cnt >= HS_LO) && (r_h_cnt < HS_HI);
    w_sync_raw.vs  = (r_v_cnt >= VS_LO) && (r_v_cnt < VS_HI);
  end

  sync_delay #(
    .DEPTH (PIX_LAT)
  ) u_sync_delay (
    .clk_83 (clk_83),
    .rst    (rst),
    .i_sync (w_sync_raw),
    .o_sync (w_sync_dly)
  );

  always_ff @(posedge clk_83) begin
    if (rst) begin
      r_rgb    <= '0;
      r_hs     <= ~HS_POL;
      r_vs     <= ~VS_POL;
      r_active <= 1'b0;
    end else begin
      r_rgb    <= w_sync_dly.vis ? w_pix : '0;
      r_hs     <= w_sync_dly.hs ? HS_POL : ~HS_POL;
      r_vs     <= w_sync_dly.vs ? VS_POL : ~VS_POL;
      r_active <= w_sync_dly.vis;
    end
  end

  assign draw_x     = r_h_cnt;
  assign draw_y     = r_v_cnt;
  assign vga_r      = r_rgb.r;
  assign vga_g      = r_rgb.g;
  assign vga_b      = r_rgb.b;
  assign vga_hs     = r_hs;
  assign vga_vs     = r_vs;
  assign active     = r_active;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench: one full-size instance for line timing, three shrunken-timing
// instances (PIX_LAT 0/1/3, 32x16 frame) for frame-level behaviour.
module tb_vga_scan_out;

  logic clk = 1'b0;
  logic rst_s = 1'b1;
  logic rst_d = 1'b1;
  logic mode_fff = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc_s = 0;
  int   cyc_d = 0;

  always #6 clk = ~clk;

  // Cycles since the last reset edge, i.e. the coordinate index currently shown.
  always @(posedge clk) begin
    cyc_s <= rst_s ? 0 : cyc_s + 1;
    cyc_d <= rst_d ? 0 : cyc_d + 1;
  end

  logic [10:0] s_x [3];
  logic [9:0]  s_y [3];
  logic [11:0] s_pix [3];
  logic [3:0]  s_r [3], s_g [3], s_b [3];
  logic        s_hs [3], s_vs [3], s_tick [3], s_act [3];

  for (genvar k = 0; k < 3; k++) begin : g_s
    localparam int LAT = (k == 2) ? 3 : k;
    logic [11:0] col;
    assign col = mode_fff ? 12'hFFF : {s_x[k][3:0], s_y[k][3:0], 4'hA};
    if (LAT == 0) begin : g_l0
      assign s_pix[k] = col;
    end else begin : g_ln
      logic [11:0] pipe [LAT];
      always @(posedge clk) begin
        pipe[0] <= col;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign s_pix[k] = pipe[LAT-1];
    end
    vga_scan_out #(
      .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
      .V_ACTIVE(10), .V_FP(1), .V_SYNC(3), .V_BP(2),
      .HS_POL(1'b0), .VS_POL(1'b1), .PIX_LAT(LAT)
    ) u_dut (
      .clk_83(clk), .rst(rst_s), .pix_rgb(s_pix[k]),
      .draw_x(s_x[k]), .draw_y(s_y[k]),
      .vga_r(s_r[k]), .vga_g(s_g[k]), .vga_b(s_b[k]),
      .vga_hs(s_hs[k]), .vga_vs(s_vs[k]),
      .frame_tick(s_tick[k]), .active(s_act[k])
    );
  end

  logic [10:0] d_x;
  logic [9:0]  d_y;
  logic [11:0] d_pix;
  logic [3:0]  d_r, d_g, d_b;
  logic        d_hs, d_vs, d_tick, d_act;

  always @(posedge clk) d_pix <= mode_fff ? 12'hFFF : {d_x[3:0], d_y[3:0], 4'hA};

  vga_scan_out u_def (
    .clk_83(clk), .rst(rst_d), .pix_rgb(d_pix),
    .draw_x(d_x), .draw_y(d_y),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
    .vga_hs(d_hs), .vga_vs(d_vs),
    .frame_tick(d_tick), .active(d_act)
  );

  function automatic int lat_of(input int k);
    return (k == 2) ? 3 : k;
  endfunction

  // Small timing: line 32 (vis 0..19, hs 23..27), frame 16 lines (vis 0..9, vs 11..13).
  function automatic logic [14:0] exp_s(input int c, input int lat, input logic fff);
    int cc, h, v;
    logic vis, hs, vs;
    logic [11:0] col;
    if (c < lat + 1) return 15'b0000_0000_0000_100;
    cc  = c - lat - 1;
    h   = cc % 32;
    v   = (cc / 32) % 16;
    vis = (h < 20) && (v < 10);
    hs  = (h >= 23) && (h <= 27);
    vs  = (v >= 11) && (v <= 13);
    col = fff ? 12'hFFF : {h[3:0], v[3:0], 4'hA};
    return {vis ? col : 12'h000, ~hs, vs, vis};
  endfunction

  // Full timing, PIX_LAT=1: hs 1344..1479, vs lines 801..803.
  function automatic logic [14:0] exp_d(input int c);
    int cc, h, v;
    logic vis, hs, vs;
    if (c < 2) return 15'b0000_0000_0000_100;
    cc  = c - 2;
    h   = cc % 1680;
    v   = (cc / 1680) % 828;
    vis = (h < 1280) && (v < 800);
    hs  = (h >= 1344) && (h <= 1479);
    vs  = (v >= 801) && (v <= 803);
    return {vis ? {h[3:0], v[3:0], 4'hA} : 12'h000, ~hs, vs, vis};
  endfunction

  task automatic pulse_rst_s();
    @(negedge clk);
    rst_s = 1'b1;
    repeat (3) @(negedge clk);
    rst_s = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    n = 0;
    while (cyc_s != 394 && n < 2000) begin @(negedge clk); n++; end
    total++;
    if (cyc_s !== 394) begin bad++; $display("FAIL rst_wait_s: cyc=%0d want=394", cyc_s); end
    total++;
    if (s_vs[1] !== 1'b1) begin bad++; $display("FAIL rst_pre_vs: vs=%b want=1", s_vs[1]); end
    rst_s = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (s_x[k] !== 11'd0 || s_y[k] !== 10'd0) begin
        bad++; $display("FAIL rst_cnt_s%0d: x=%0d y=%0d want 0,0", k, s_x[k], s_y[k]);
      end
      total++;
      if ({s_r[k], s_g[k], s_b[k], s_hs[k], s_vs[k], s_act[k], s_tick[k]} !== 16'h0008) begin
        bad++; $display("FAIL rst_pins_s%0d: got=%h want=0008", k,
                        {s_r[k], s_g[k], s_b[k], s_hs[k], s_vs[k], s_act[k], s_tick[k]});
      end
    end
    repeat (2) @(negedge clk);
    rst_s = 1'b0;

    n = 0;
    while (cyc_d != 700 && n < 2000) begin @(negedge clk); n++; end
    total++;
    if (d_x !== 11'd700 || d_y !== 10'd0) begin
      bad++; $display("FAIL rst_pre_d: x=%0d y=%0d want 700,0", d_x, d_y);
    end
    rst_d = 1'b1;
    @(negedge clk);
    total++;
    if (d_x !== 11'd0 || d_y !== 10'd0) begin
      bad++; $display("FAIL rst_cnt_d: x=%0d y=%0d want 0,0", d_x, d_y);
    end
    total++;
    if ({d_r, d_g, d_b, d_hs, d_vs, d_act, d_tick} !== 16'h0008) begin
      bad++; $display("FAIL rst_pins_d: got=%h want=0008", {d_r, d_g, d_b, d_hs, d_vs, d_act, d_tick});
    end
    repeat (2) @(negedge clk);
    rst_d = 1'b0;
  endtask

  task automatic test_hsync();
    int errs, nfall, f0, f1, w0, c, fc;
    logic prev;
    logic [14:0] got, expv, fg, fe;
    errs = 0; nfall = 0; f0 = -1; f1 = -1; w0 = -1; fc = -1; prev = 1'b1;
    fg = '0; fe = '0;
    @(negedge clk);
    rst_d = 1'b1;
    repeat (3) @(negedge clk);
    rst_d = 1'b0;
    for (int i = 0; i < 3400; i++) begin
      c    = cyc_d;
      got  = {d_r, d_g, d_b, d_hs, d_vs, d_act};
      expv = exp_d(c);
      if (got !== expv || d_x !== 11'(c % 1680) || d_y !== 10'(c / 1680)) begin
        if (errs == 0) begin fc = c; fg = got; fe = expv; end
        errs++;
      end
      if (prev && !d_hs) begin
        if (nfall == 0) f0 = c; else if (nfall == 1) f1 = c;
        nfall++;
      end
      if (!prev && d_hs && w0 < 0) w0 = c - f0;
      prev = d_hs;
      @(negedge clk);
    end
    total++;
    if (nfall !== 2) begin bad++; $display("FAIL hs_count: got=%0d want=2", nfall); end
    total++;
    if (f0 !== 1346) begin bad++; $display("FAIL hs_first_fall: got=%0d want=1346", f0); end
    total++;
    if (f1 - f0 !== 1680) begin bad++; $display("FAIL hs_period: got=%0d want=1680", f1 - f0); end
    total++;
    if (w0 !== 136) begin bad++; $display("FAIL hs_width: got=%0d want=136", w0); end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL line_scan_d: %0d bad cycles, first c=%0d got=%h want=%h", errs, fc, fg, fe);
    end
  endtask

  task automatic test_vertical();
    int nrise [3], r0 [3], r1 [3], wid [3];
    logic prev [3];
    logic [10:0] px [3];
    logic [9:0]  py [3];
    int c, errs, wraps, werr;
    errs = 0; wraps = 0; werr = 0;
    for (int k = 0; k < 3; k++) begin
      nrise[k] = 0; r0[k] = -1; r1[k] = -1; wid[k] = -1; prev[k] = 1'b0;
      px[k] = '0; py[k] = '0;
    end
    pulse_rst_s();
    for (int i = 0; i < 1100; i++) begin
      c = cyc_s;
      for (int k = 0; k < 3; k++) begin
        if (s_x[k] !== 11'(c % 32) || s_y[k] !== 10'((c / 32) % 16)) errs++;
        if (py[k] == 10'd15 && s_y[k] == 10'd0) begin
          wraps++;
          if (px[k] !== 11'd31 || s_x[k] !== 11'd0) werr++;
        end
        if (!prev[k] && s_vs[k]) begin
          if (nrise[k] == 0) r0[k] = c; else if (nrise[k] == 1) r1[k] = c;
          nrise[k]++;
        end
        if (prev[k] && !s_vs[k] && wid[k] < 0) wid[k] = c - r0[k];
        prev[k] = s_vs[k];
        px[k] = s_x[k];
        py[k] = s_y[k];
      end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (nrise[k] !== 2) begin bad++; $display("FAIL vs_count_s%0d: got=%0d want=2", k, nrise[k]); end
      total++;
      if (r0[k] !== 353 + lat_of(k)) begin
        bad++; $display("FAIL vs_start_s%0d: got=%0d want=%0d", k, r0[k], 353 + lat_of(k));
      end
      total++;
      if (r1[k] - r0[k] !== 512) begin
        bad++; $display("FAIL vs_period_s%0d: got=%0d want=512", k, r1[k] - r0[k]);
      end
      total++;
      if (wid[k] !== 96) begin bad++; $display("FAIL vs_width_s%0d: got=%0d want=96", k, wid[k]); end
    end
    total++;
    if (wraps !== 6) begin bad++; $display("FAIL frame_wraps: got=%0d want=6", wraps); end
    total++;
    if (werr !== 0) begin bad++; $display("FAIL wrap_align: got=%0d bad wraps want=0", werr); end
    total++;
    if (errs !== 0) begin bad++; $display("FAIL draw_scan: got=%0d bad samples want=0", errs); end
  endtask

  task automatic test_latency();
    int errs [3], nact [3], fc [3];
    logic [14:0] got, expv;
    logic [14:0] fg [3], fe [3];
    int c;
    for (int k = 0; k < 3; k++) begin
      errs[k] = 0; nact[k] = 0; fc[k] = -1; fg[k] = '0; fe[k] = '0;
    end
    mode_fff = 1'b0;
    pulse_rst_s();
    for (int i = 0; i < 512; i++) begin
      c = cyc_s;
      for (int k = 0; k < 3; k++) begin
        got  = {s_r[k], s_g[k], s_b[k], s_hs[k], s_vs[k], s_act[k]};
        expv = exp_s(c, lat_of(k), 1'b0);
        if (got !== expv) begin
          if (errs[k] == 0) begin fc[k] = c; fg[k] = got; fe[k] = expv; end
          errs[k]++;
        end
        if (s_act[k]) nact[k]++;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (errs[k] !== 0) begin
        bad++; $display("FAIL latency_s%0d: %0d bad cycles, first c=%0d got=%h want=%h",
                        k, errs[k], fc[k], fg[k], fe[k]);
      end
      total++;
      if (nact[k] !== 200) begin bad++; $display("FAIL active_count_s%0d: got=%0d want=200", k, nact[k]); end
    end
  endtask

  task automatic test_blanking();
    int errs [3], leak [3], nvis [3];
    int c;
    for (int k = 0; k < 3; k++) begin errs[k] = 0; leak[k] = 0; nvis[k] = 0; end
    mode_fff = 1'b1;
    pulse_rst_s();
    for (int i = 0; i < 512; i++) begin
      c = cyc_s;
      for (int k = 0; k < 3; k++) begin
        if ({s_r[k], s_g[k], s_b[k], s_hs[k], s_vs[k], s_act[k]} !== exp_s(c, lat_of(k), 1'b1)) errs[k]++;
        if (!s_act[k] && {s_r[k], s_g[k], s_b[k]} !== 12'h000) leak[k]++;
        if (s_act[k] && {s_r[k], s_g[k], s_b[k]} === 12'hFFF) nvis[k]++;
      end
      @(negedge clk);
    end
    mode_fff = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (leak[k] !== 0) begin bad++; $display("FAIL blank_leak_s%0d: got=%0d want=0", k, leak[k]); end
      total++;
      if (nvis[k] !== 200) begin bad++; $display("FAIL blank_vis_s%0d: got=%0d want=200", k, nvis[k]); end
      total++;
      if (errs[k] !== 0) begin bad++; $display("FAIL blank_scan_s%0d: got=%0d bad want=0", k, errs[k]); end
    end
  endtask

  task automatic test_frame_tick();
    int n [3], t0 [3], t1 [3], t2 [3], perr [3], multi [3];
    logic prev [3];
    int c;
    for (int k = 0; k < 3; k++) begin
      n[k] = 0; t0[k] = -1; t1[k] = -1; t2[k] = -1; perr[k] = 0; multi[k] = 0; prev[k] = 1'b0;
    end
    pulse_rst_s();
    for (int i = 0; i < 1600; i++) begin
      c = cyc_s;
      for (int k = 0; k < 3; k++) begin
        if (s_tick[k]) begin
          if (n[k] == 0) t0[k] = c; else if (n[k] == 1) t1[k] = c; else if (n[k] == 2) t2[k] = c;
          n[k]++;
          if (s_x[k] !== 11'd0 || s_y[k] !== 10'd10) perr[k]++;
          if (prev[k]) multi[k]++;
        end
        prev[k] = s_tick[k];
      end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (n[k] !== 3) begin bad++; $display("FAIL tick_count_s%0d: got=%0d want=3", k, n[k]); end
      total++;
      if (t0[k] !== 320) begin bad++; $display("FAIL tick_first_s%0d: got=%0d want=320", k, t0[k]); end
      total++;
      if (t1[k] - t0[k] !== 512 || t2[k] - t1[k] !== 512) begin
        bad++; $display("FAIL tick_spacing_s%0d: got=%0d,%0d want=512,512", k, t1[k] - t0[k], t2[k] - t1[k]);
      end
      total++;
      if (perr[k] !== 0 || multi[k] !== 0) begin
        bad++; $display("FAIL tick_shape_s%0d: offpos=%0d multi=%0d want 0,0", k, perr[k], multi[k]);
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_s = 1'b0;
    rst_d = 1'b0;
    test_reset();
    test_hsync();
    test_vertical();
    test_latency();
    test_blanking();
    test_frame_tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
